// File: rtl/dcache_hold_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache controller for the MEM stage.
// A miss raises hold_o to freeze the pipeline until the line has been written back and refilled.
module dcache_hold_ctrl #(
  parameter int INDEX_BITS = 5,
  parameter int LINE_BITS  = 128
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cpu_req_i,
  input  logic                 cpu_we_i,
  input  logic [31:0]          cpu_addr_i,
  input  logic [31:0]          cpu_wdata_i,
  output logic [31:0]          cpu_rdata_o,
  output logic                 hold_o,
  output logic                 mem_req_o,
  output logic                 mem_we_o,
  output logic [31:0]          mem_addr_o,
  output logic [LINE_BITS-1:0] mem_wdata_o,
  input  logic                 mem_ack_i,
  input  logic [LINE_BITS-1:0] mem_rdata_i
);
  // state     | meaning
  // IDLE      | serving hits; a miss is detected here
  // WRITEBACK | writing the dirty victim line to memory
  // ALLOCATE  | fetching the requested line from memory
  // RESOLVE   | fill written; one settle cycle before the access hits in IDLE

  localparam int NUM_LINES = 2**INDEX_BITS;
  localparam int TAG_BITS  = 32 - INDEX_BITS - 4;
  localparam int WSEL_BITS = $clog2(LINE_BITS);

  typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE, RESOLVE} state_t;

  state_t state, state_next;

  logic [NUM_LINES-1:0] valid_q;
  logic [NUM_LINES-1:0] dirty_q;
  logic [TAG_BITS-1:0]  tag_q  [NUM_LINES];
  logic [LINE_BITS-1:0] data_q [NUM_LINES];
  logic [LINE_BITS-1:0] victim_line;
  logic [31:0]          victim_addr;

  logic [1:0]            offset;
  logic [INDEX_BITS-1:0] index;
  logic [TAG_BITS-1:0]   tag;
  logic [WSEL_BITS-1:0]  word_lsb;
  logic                  hit;
  logic                  victim_dirty;
  logic                  miss_idle;
  logic                  store_hit;
  logic                  fill_done;
  logic                  unused_addr_bits;

  assign offset           = cpu_addr_i[3:2];
  assign index            = cpu_addr_i[INDEX_BITS+3:4];
  assign tag              = cpu_addr_i[31:INDEX_BITS+4];
  assign word_lsb         = WSEL_BITS'({offset, 5'b0});
  assign unused_addr_bits = ^cpu_addr_i[1:0];

  assign hit          = cpu_req_i & valid_q[index] & (tag_q[index] == tag);
  assign victim_dirty = valid_q[index] & dirty_q[index];
  assign miss_idle    = (state == IDLE) & cpu_req_i & ~hit;
  assign store_hit    = (state == IDLE) & hit & cpu_we_i;
  assign fill_done    = (state == ALLOCATE) & mem_ack_i;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (miss_idle) begin
          state_next = victim_dirty ? WRITEBACK : ALLOCATE;
        end
      end
      WRITEBACK: begin
        if (mem_ack_i) begin
          state_next = ALLOCATE;
        end
      end
      ALLOCATE: begin
        if (mem_ack_i) begin
          state_next = RESOLVE;
        end
      end
      RESOLVE:  state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // Everything is forced quiet while reset is high, even if a transaction was in flight.
  always_comb begin
    hold_o      = 1'b0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (!reset) begin
      case (state)
        IDLE: begin
          hold_o = miss_idle;
        end
        WRITEBACK: begin
          hold_o      = 1'b1;
          mem_req_o   = 1'b1;
          mem_we_o    = 1'b1;
          mem_addr_o  = victim_addr;
          mem_wdata_o = victim_line;
        end
        ALLOCATE: begin
          hold_o     = 1'b1;
          mem_req_o  = 1'b1;
          mem_addr_o = {cpu_addr_i[31:4], 4'b0};
        end
        RESOLVE: begin
          hold_o = 1'b1;
        end
        default: begin
          hold_o = 1'b0;
        end
      endcase
    end
  end

  assign cpu_rdata_o = reset ? 32'h0 : data_q[index][word_lsb +: 32];

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (fill_done) begin
      valid_q[index] <= 1'b1;
      dirty_q[index] <= 1'b0;
    end else if (store_hit) begin
      dirty_q[index] <= 1'b1;
    end
  end

  // Tag and data arrays carry no reset; valid_q alone decides whether their contents count.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (fill_done) begin
        tag_q[index]  <= tag;
        data_q[index] <= mem_rdata_i;
      end else if (store_hit) begin
        data_q[index][word_lsb +: 32] <= cpu_wdata_i;
      end
    end
  end

  // The victim is captured so the write-back stays stable while the indexed line is refilled.
  always_ff @(posedge clk) begin
    if (reset) begin
      victim_line <= '0;
      victim_addr <= '0;
    end else if (miss_idle && victim_dirty) begin
      victim_line <= data_q[index];
      victim_addr <= {tag_q[index], index, 4'b0};
    end
  end

endmodule
